// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for serial_adder
//
// Purpose: groups the operand-in and result-out handshakes of serial_adder.
// Optional macro: SERIAL_ADDER_OVF_EN adds out_ovf (signed overflow flag).
//
// Signals:
//   in_valid  producer -> adder  operand set offered
//   in_ready  adder -> producer  adder can accept operands
//   in_a      producer -> adder  operand A, WIDTH bits
//   in_b      producer -> adder  operand B, WIDTH bits
//   in_cin    producer -> adder  carry-in for bit 0
//   out_valid adder -> consumer  result available
//   out_ready consumer -> adder  consumer accepts result
//   out_sum   adder -> consumer  sum bits, bit 0 = LSB
//   out_cout  adder -> consumer  carry out of bit WIDTH-1
//   busy      adder -> anyone    adder is not idle
//   out_ovf   adder -> consumer  signed overflow (SERIAL_ADDER_OVF_EN only)
//
// Modports: master = producer/consumer side, slave = adder side.

interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             out_ovf;
`endif

`ifdef SERIAL_ADDER_OVF_EN
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );
`endif

endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first ripple adder with valid/ready handshakes
//
// Purpose: adds two WIDTH-bit operands plus carry-in using a single full-adder
// cell, one bit per clock, LSB first. Result = {out_cout, out_sum} =
// in_a + in_b + in_cin. One operation takes WIDTH+2 cycles end to end
// (accept, WIDTH shift edges, consume).
// Optional macro: SERIAL_ADDER_OVF_EN adds bus.out_ovf, the signed overflow
// flag (carry into MSB xor carry out of MSB), reset to 0 and held with out_sum.
//
// Ports:
//   clk  input  single clock, rising edge
//   rst  input  asynchronous active-high reset
//   bus  serial_adder_if.slave  operand/result handshakes, out_sum, out_cout, busy
//
// Parameters:
//   WIDTH  operand/sum width in bits, 2..32

module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  // One spare bit so the counter never wraps, even at WIDTH = 32.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;
  logic [WIDTH-1:0] acc_shifted;

  // The single full-adder cell works on the current LSBs of the operand
  // shift registers and the running carry.
  always_comb begin
    fa_sum      = a_q[0] ^ b_q[0] ^ carry_q;
    fa_carry    = (a_q[0] & b_q[0]) | (b_q[0] & carry_q) | (carry_q & a_q[0]);
    last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
    // New bits enter at the MSB end; after WIDTH shifts bit 0 sits at the LSB.
    acc_shifted = {fa_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_shifted;
        carry_d = fa_carry;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          // The visible result is only updated on completion so that it
          // keeps showing the previous result while a new add is in flight.
          sum_d   = acc_shifted;
          cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB cell.
          ovf_d   = carry_q ^ fa_carry;
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the next state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8)

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Expected {ovf, cout, sum}, pushed when operands are offered.
  logic [WIDTH+1:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin);
    logic [WIDTH:0] s;
    logic           ovf;
    s   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return {ovf, s};
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int hold);
    logic [WIDTH+1:0] exp;
    int               lat;
    chk("idle_in_ready", bus.in_ready, 1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    sb_q.push_back(model(a, b, cin));
    step();
    // Scramble operands and keep offering: the adder must ignore both.
    bus.in_a   = WIDTH'($urandom);
    bus.in_b   = WIDTH'($urandom);
    bus.in_cin = 1'($urandom);
    chk("shift_in_ready", bus.in_ready, 0);
    chk("shift_busy", bus.busy, 1);
    chk("shift_out_valid", bus.out_valid, 0);
    lat = 0;
    while (!bus.out_valid && lat < 3 * WIDTH) begin
      step();
      lat++;
      if (lat == 3) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("latency", lat, WIDTH);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      exp = '0;
    end else begin
      exp = sb_q.pop_front();
    end
    chk("out_sum", bus.out_sum, exp[WIDTH-1:0]);
    chk("out_cout", bus.out_cout, exp[WIDTH]);
`ifdef SERIAL_ADDER_OVF_EN
    chk("out_ovf", bus.out_ovf, exp[WIDTH+1]);
`endif
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_sum", bus.out_sum, exp[WIDTH-1:0]);
      chk("bp_out_cout", bus.out_cout, exp[WIDTH]);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
    chk("post_busy", bus.busy, 0);
    chk("post_out_sum_held", bus.out_sum, exp[WIDTH-1:0]);
    chk("post_out_cout_held", bus.out_cout, exp[WIDTH]);
  endtask

  initial begin
    logic [2:0] bits;
    logic       seen_valid;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_cout", bus.out_cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_out_ovf", bus.out_ovf, 0);
`endif
    rst = 1'b0;
    step();

    // Directed sums
    run_op(8'h0F, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    // Backpressure held for 5 cycles
    run_op(8'h5A, 8'h3C, 1'b1, 5);

    // Full-adder truth table on bit 0
    for (int i = 0; i < 8; i++) begin
      bits = 3'(i);
      run_op({7'd0, bits[2]}, {7'd0, bits[1]}, bits[0], 0);
      chk("fa_sum_bit0", bus.out_sum[0], bits[2] ^ bits[1] ^ bits[0]);
      chk("fa_carry_bit1", bus.out_sum[1],
          (bits[2] & bits[1]) | (bits[1] & bits[0]) | (bits[0] & bits[2]));
    end

    // Signed overflow corners (plain sums in the default build)
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'hFF, 1'b0, 0);
    run_op(8'h01, 8'h01, 1'b0, 0);

    // Random operands
    for (int i = 0; i < 4; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), i);
    end

    // Leave a nonzero held result, then reset 3 edges into an operation
    run_op(8'h12, 8'h34, 1'b0, 0);
    bus.in_a     = 8'h55;
    bus.in_b     = 8'h33;
    bus.in_cin   = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_sum", bus.out_sum, 0);
    chk("midrst_out_cout", bus.out_cout, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_busy", bus.busy, 0);
    step();
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      step();
      if (bus.out_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_late_valid", seen_valid, 0);
    chk("midrst_idle_in_ready", bus.in_ready, 1);

    // Recovery after reset
    run_op(8'hA5, 8'h5A, 1'b1, 2);

    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
